// File: rtl/mac_seq_divider_if.sv
// mac_seq_divider_if: valid/ready operand and result bundle for the sequential divider
interface mac_seq_divider_if #(
    parameter int DW_N = 16,
    parameter int DW_D = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [DW_N-1:0] dividend;
    logic [DW_D-1:0] divisor;
    logic            out_valid;
    logic            out_ready;
    logic [DW_N-1:0] quotient;
    logic [DW_D-1:0] remainder;
    logic            div_by_zero;
    logic            busy;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );
endinterface

// File: rtl/mac_seq_divider.sv
// mac_seq_divider: radix-2 restoring divider, one quotient bit per cycle, valid/ready both sides.
// DIV_SIGNED_EN selects two's complement operands (truncating quotient, remainder follows dividend).
module mac_seq_divider #(
    parameter int DW_N = 16,
    parameter int DW_D = 8
) (
    input  logic              clk,
    input  logic              rst,
    mac_seq_divider_if.slave  bus
);
    localparam int CW = $clog2(DW_N + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [DW_N-1:0] q_q;
    logic [DW_D-1:0] rem_q;
    logic [DW_D-1:0] dvs_q;
    logic            dz_q;
    logic [DW_N-1:0] quo_q;
    logic [DW_D-1:0] rmd_q;
    logic            dzo_q;
    logic [DW_D:0]   shifted, trial;
    logic [DW_D-1:0] rem_nxt, rem_fin, mag_d;
    logic [DW_N-1:0] q_nxt, q_fin, mag_n;
    logic            accept, last;

    assign accept = state_q == IDLE && bus.in_valid;
    assign last   = state_q == CALC && cnt_q == CW'(1);

    // Remainder stays below the divisor, so the DW_D+1-bit trial is signed-safe.
    assign shifted = {rem_q, q_q[DW_N-1]};
    assign trial   = shifted - {1'b0, dvs_q};
    assign rem_nxt = trial[DW_D] ? shifted[DW_D-1:0] : trial[DW_D-1:0];
    assign q_nxt   = {q_q[DW_N-2:0], ~trial[DW_D]};

`ifdef DIV_SIGNED_EN
    logic sq_q, sn_q;
    assign mag_n   = bus.dividend[DW_N-1] ? -bus.dividend : bus.dividend;
    assign mag_d   = bus.divisor[DW_D-1] ? -bus.divisor : bus.divisor;
    assign q_fin   = sq_q ? -q_nxt : q_nxt;
    assign rem_fin = sn_q ? -rem_nxt : rem_nxt;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sq_q <= 1'b0;
            sn_q <= 1'b0;
        end else if (accept) begin
            sq_q <= bus.dividend[DW_N-1] ^ bus.divisor[DW_D-1];
            sn_q <= bus.dividend[DW_N-1];
        end
`else
    assign mag_n   = bus.dividend;
    assign mag_d   = bus.divisor;
    assign q_fin   = q_nxt;
    assign rem_fin = rem_nxt;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;

    always_comb
        state_d = accept                          ? CALC :
                  last                            ? DONE :
                  state_q == DONE && bus.out_ready ? IDLE : state_q;

    always_comb begin
        bus.in_ready  = state_q == IDLE;
        bus.busy      = state_q == CALC;
        bus.out_valid = state_q == DONE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt_q <= '0;
            q_q   <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            dz_q  <= 1'b0;
            quo_q <= '0;
            rmd_q <= '0;
            dzo_q <= 1'b0;
        end else if (accept) begin
            cnt_q <= CW'(DW_N);
            q_q   <= mag_n;
            rem_q <= '0;
            dvs_q <= mag_d;
            dz_q  <= bus.divisor == '0;
        end else if (state_q == CALC) begin
            cnt_q <= cnt_q - CW'(1);
            q_q   <= q_nxt;
            rem_q <= rem_nxt;
            if (last) begin
                quo_q <= dz_q ? '1 : q_fin;
                rmd_q <= dz_q ? '0 : rem_fin;
                dzo_q <= dz_q;
            end
        end

    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmd_q;
    assign bus.div_by_zero = dzo_q;
endmodule

// File: tb/tb_mac_seq_divider.sv
// tb_mac_seq_divider: directed vectors with hand-computed quotients, remainders and latencies.
module tb_mac_seq_divider;
    localparam int DW_N = 16;
    localparam int DW_D = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mac_seq_divider_if #(.DW_N(DW_N), .DW_D(DW_D)) bus ();
    mac_seq_divider #(.DW_N(DW_N), .DW_D(DW_D)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start(input string tag, input logic [DW_N-1:0] n, input logic [DW_D-1:0] d);
        check({tag, "_rdy"}, 32'(bus.in_ready), 1);
        bus.dividend = n;
        bus.divisor  = d;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, "_busy"}, 32'(bus.busy), 1);
        check({tag, "_rdy_calc"}, 32'(bus.in_ready), 0);
    endtask

    task automatic wait_done(input string tag);
        int c = 0;
        while (!bus.out_valid && c < 40) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_lat"}, 32'(c), 16);
    endtask

    task automatic run(input string tag, input logic [DW_N-1:0] n, input logic [DW_D-1:0] d,
                       input logic [DW_N-1:0] eq, input logic [DW_D-1:0] er, input logic edz);
        start(tag, n, d);
        wait_done(tag);
        check({tag, "_q"}, 32'(bus.quotient), 32'(eq));
        check({tag, "_r"}, 32'(bus.remainder), 32'(er));
        check({tag, "_dz"}, 32'(bus.div_by_zero), 32'(edz));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_ov_drop"}, 32'(bus.out_valid), 0);
        check({tag, "_rdy_idle"}, 32'(bus.in_ready), 1);
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (2) @(negedge clk);
        check("rst_rdy", 32'(bus.in_ready), 1);
        check("rst_ov", 32'(bus.out_valid), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_q", 32'(bus.quotient), 0);
        rst = 1'b0;
        @(negedge clk);

        run("t1", 16'd100, 8'd7, 16'd14, 8'd2, 1'b0);
        run("t2a", 16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0);
        run("t2b", 16'h0005, 8'h09, 16'h0000, 8'h05, 1'b0);
        run("t3a", 16'd1234, 8'd0, 16'hFFFF, 8'h00, 1'b1);
        run("t3b", 16'd10, 8'd3, 16'd3, 8'd1, 1'b0);

        start("t4", 16'd1000, 8'd10);
        wait_done("t4");
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.dividend = 16'd77;
                bus.divisor  = 8'd7;
                bus.in_valid = 1'b1;
            end
            @(negedge clk);
            bus.in_valid = 1'b0;
            check("t4_hold_ov", 32'(bus.out_valid), 1);
            check("t4_hold_q", 32'(bus.quotient), 100);
            check("t4_hold_r", 32'(bus.remainder), 0);
            check("t4_hold_rdy", 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("t4_ov_drop", 32'(bus.out_valid), 0);
        check("t4_rdy", 32'(bus.in_ready), 1);
        check("t4_no_calc", 32'(bus.busy), 0);
        check("t4_q_kept", 32'(bus.quotient), 100);

        start("t5", 16'd50000, 8'd3);
        repeat (7) @(negedge clk);
        check("t5_busy_pre", 32'(bus.busy), 1);
        rst = 1'b1;
        #1;
        check("t5_rst_rdy", 32'(bus.in_ready), 1);
        check("t5_rst_busy", 32'(bus.busy), 0);
        check("t5_rst_ov", 32'(bus.out_valid), 0);
        check("t5_rst_q", 32'(bus.quotient), 0);
        check("t5_rst_r", 32'(bus.remainder), 0);
        check("t5_rst_dz", 32'(bus.div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5_no_out", 32'(bus.out_valid), 0);
        run("t5b", 16'd200, 8'd13, 16'd15, 8'd5, 1'b0);

`ifdef DIV_SIGNED_EN
        run("t6s", 16'hFF9C, 8'd7, 16'hFFF2, 8'hFE, 1'b0);
        run("t6ovf", 16'h8000, 8'hFF, 16'h8000, 8'h00, 1'b0);
        run("t6neg", 16'd100, 8'hF9, 16'hFFF2, 8'h02, 1'b0);
`else
        run("t6u", 16'hFF9C, 8'd7, 16'd9348, 8'd0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
